adbg_spr_arbiter: RTL and testbench



---
 rtl/adbg_pkg.sv | 20 ++
 rtl/adbg_rr_pick.sv | 32 +++
 rtl/adbg_spr_arbiter.sv | 110 +++++++++++
 tb/tb_adbg_spr_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/adbg_pkg.sv
// Shared types and constants for the SPR debug-port arbiter.
package adbg_pkg;

    localparam int unsigned SPR_ADDR_W = 16;
    localparam int unsigned SPR_DATA_W = 32;

    localparam logic [SPR_DATA_W-1:0] TIMEOUT_DATA = 32'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } spr_arb_state_e;

    // Index width for n requesters; never below one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adbg_rr_pick.sv
// Combinational round-robin picker: first active request at or above the pointer, with wrap.
module adbg_rr_pick
    import adbg_pkg::*;
#(
    parameter int unsigned N = 2,
    localparam int unsigned IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant_c,
    output logic [IDX_W-1:0] o_idx_c,
    output logic             o_valid_c
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_grant_c = '0;
        o_idx_c   = '0;
        o_valid_c = 1'b0;
        w_cand    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_cand = IDX_W'((32'(i_ptr) + i) % N);
            if (!o_valid_c && i_req[w_cand]) begin
                o_valid_c         = 1'b1;
                o_grant_c[w_cand] = 1'b1;
                o_idx_c           = w_cand;
            end
        end
    end

endmodule

// File: rtl/adbg_spr_arbiter.sv
// Round-robin arbiter sharing one OR1K SPR debug port between several requesters,
// with a watchdog that aborts transactions the core never acknowledges.
module adbg_spr_arbiter
    import adbg_pkg::*;
#(
    parameter int unsigned NB_MASTERS     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                                   cpu_clk_i,
    input  logic                                   cpu_rst_i,
    input  logic [NB_MASTERS-1:0]                  m_stb_i,
    input  logic [NB_MASTERS-1:0]                  m_we_i,
    input  logic [NB_MASTERS-1:0][SPR_ADDR_W-1:0]  m_addr_i,
    input  logic [NB_MASTERS-1:0][SPR_DATA_W-1:0]  m_data_i,
    output logic [NB_MASTERS-1:0]                  m_ack_o,
    output logic [NB_MASTERS-1:0]                  m_err_o,
    output logic [SPR_DATA_W-1:0]                  m_data_o,
    output logic                                   spr_stb_o,
    output logic                                   spr_we_o,
    output logic [SPR_ADDR_W-1:0]                  spr_addr_o,
    output logic [SPR_DATA_W-1:0]                  spr_data_o,
    input  logic [SPR_DATA_W-1:0]                  spr_data_i,
    input  logic                                   spr_ack_i
);

    localparam int unsigned IDX_W = idx_w(NB_MASTERS);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    spr_arb_state_e         r_state;
    logic [IDX_W-1:0]       r_rr_ptr;
    logic [CNT_W-1:0]       r_cnt;
    logic [NB_MASTERS-1:0]  r_gnt;

    logic [NB_MASTERS-1:0]  w_grant;
    logic [IDX_W-1:0]       w_idx;
    logic                   w_valid;

    adbg_rr_pick #(
        .N (NB_MASTERS)
    ) u_pick (
        .i_req     (m_stb_i),
        .i_ptr     (r_rr_ptr),
        .o_grant_c (w_grant),
        .o_idx_c   (w_idx),
        .o_valid_c (w_valid)
    );

    // The SPR bus outputs double as the latched request registers while in XFER.
    always_ff @(posedge cpu_clk_i) begin
        if (cpu_rst_i) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_cnt      <= '0;
            r_gnt      <= '0;
            m_ack_o    <= '0;
            m_err_o    <= '0;
            m_data_o   <= '0;
            spr_stb_o  <= 1'b0;
            spr_we_o   <= 1'b0;
            spr_addr_o <= '0;
            spr_data_o <= '0;
        end else begin
            m_ack_o <= '0;
            m_err_o <= '0;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_gnt      <= w_grant;
                        r_rr_ptr   <= IDX_W'((32'(w_idx) + 32'd1) % NB_MASTERS);
                        r_cnt      <= '0;
                        spr_stb_o  <= 1'b1;
                        spr_we_o   <= m_we_i[w_idx];
                        spr_addr_o <= m_addr_i[w_idx];
                        spr_data_o <= m_data_i[w_idx];
                        r_state    <= XFER;
                    end
                end
                XFER: begin
                    if (spr_ack_i || (r_cnt == CNT_LAST)) begin
                        // Ack wins over a timeout landing in the same cycle.
                        if (spr_ack_i) begin
                            if (!spr_we_o) begin
                                m_data_o <= spr_data_i;
                            end
                        end else begin
                            m_err_o  <= r_gnt;
                            m_data_o <= TIMEOUT_DATA;
                        end
                        m_ack_o    <= r_gnt;
                        spr_stb_o  <= 1'b0;
                        spr_we_o   <= 1'b0;
                        spr_addr_o <= '0;
                        spr_data_o <= '0;
                        r_state    <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adbg_spr_arbiter.sv
// Randomized bench for adbg_spr_arbiter against a transaction-timestamp reference model.
module tb_adbg_spr_arbiter;

    localparam int unsigned NB   = 3;
    localparam int unsigned TO   = 6;
    localparam int          NCYC = 1500;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NB-1:0]         m_stb;
    logic [NB-1:0]         m_we;
    logic [NB-1:0][15:0]   m_addr;
    logic [NB-1:0][31:0]   m_wdata;
    logic [NB-1:0]         m_ack;
    logic [NB-1:0]         m_err;
    logic [31:0]           m_rdata;
    logic                  spr_stb;
    logic                  spr_we;
    logic [15:0]           spr_addr;
    logic [31:0]           spr_wdata;
    logic [31:0]           spr_rdata;
    logic                  spr_ack;

    adbg_spr_arbiter #(
        .NB_MASTERS     (NB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .cpu_clk_i  (clk),
        .cpu_rst_i  (rst),
        .m_stb_i    (m_stb),
        .m_we_i     (m_we),
        .m_addr_i   (m_addr),
        .m_data_i   (m_wdata),
        .m_ack_o    (m_ack),
        .m_err_o    (m_err),
        .m_data_o   (m_rdata),
        .spr_stb_o  (spr_stb),
        .spr_we_o   (spr_we),
        .spr_addr_o (spr_addr),
        .spr_data_o (spr_wdata),
        .spr_data_i (spr_rdata),
        .spr_ack_i  (spr_ack)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic int pick(input logic [NB-1:0] req, input int p);
        for (int i = 0; i < int'(NB); i++) begin
            if (req[(p + i) % NB]) return (p + i) % NB;
        end
        return -1;
    endfunction

    // Model: one transaction described by its grant cycle, strobe length and outcome.
    bit           have_txn;
    int           t_grant, len, lat, g, ptr, next_idle;
    bit           txn_err;
    logic         e_we;
    logic [15:0]  e_addr;
    logic [31:0]  e_wdata;
    logic [31:0]  mdata;
    int           lat_q[$];
    int           obs_q[$];
    int           exp_order[4];
    int           rst_cyc, post_rst_idx, gi;
    bit           rst_armed, in_str, is_done, locked, force_raise;
    logic [NB-1:0] exp_ack, exp_err;

    initial begin
        rst = 1'b1; m_stb = '0; m_we = '0; m_addr = '0; m_wdata = '0;
        spr_ack = 1'b0; spr_rdata = '0;
        lat_q = '{1, 5, 0, int'(TO), 0, 1};
        exp_order = '{0, 1, 2, 0};
        have_txn = 0; t_grant = 0; len = 0; lat = 0; g = 0; ptr = 0; next_idle = 1;
        txn_err = 0; e_we = 0; e_addr = '0; e_wdata = '0; mdata = '0;
        rst_cyc = -10; post_rst_idx = -1; rst_armed = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_spr_stb", 32'(spr_stb), 32'h0);
        check("rst_spr_we", 32'(spr_we), 32'h0);
        check("rst_spr_addr", 32'(spr_addr), 32'h0);
        check("rst_spr_data", spr_wdata, 32'h0);
        check("rst_m_ack", 32'(m_ack), 32'h0);
        check("rst_m_err", 32'(m_err), 32'h0);
        check("rst_m_data", m_rdata, 32'h0);

        for (cyc = 1; cyc <= NCYC; cyc++) begin
            @(posedge clk);
            #1;
            in_str  = have_txn && cyc >= t_grant + 1 && cyc <= t_grant + len;
            is_done = have_txn && cyc == t_grant + len + 1;

            if (cyc == 600) rst_armed = 1;
            rst = 1'b0;
            if (rst_armed && in_str) begin
                rst = 1'b1; rst_armed = 0; rst_cyc = cyc;
            end

            force_raise = (cyc <= 40) || (cyc == rst_cyc + 1);
            for (int i = 0; i < int'(NB); i++) begin
                locked = have_txn && i == g && cyc <= t_grant + len + 1;
                if (have_txn && i == g && cyc == t_grant + len + 2) begin
                    m_stb[i] = 1'b0;
                end else if (locked) begin
                    // A granted master may give up early; it must still get its ack.
                    if (m_stb[i] && $urandom_range(0, 9) == 0) m_stb[i] = 1'b0;
                end else if (!m_stb[i] && (force_raise || $urandom_range(0, 3) == 0)) begin
                    m_stb[i]   = 1'b1;
                    m_we[i]    = 1'($urandom);
                    m_addr[i]  = 16'($urandom);
                    m_wdata[i] = $urandom;
                end
            end

            spr_rdata = $urandom;
            if (cyc == rst_cyc + 1)
                spr_ack = 1'b1;
            else if (in_str)
                spr_ack = (lat != 0) && (cyc == t_grant + lat);
            else
                spr_ack = ($urandom_range(0, 7) == 0);

            @(negedge clk);
            exp_ack = is_done ? NB'(1 << g) : '0;
            exp_err = (is_done && txn_err) ? NB'(1 << g) : '0;
            check("spr_stb", 32'(spr_stb), 32'(in_str));
            check("spr_we", 32'(spr_we), in_str ? 32'(e_we) : 32'h0);
            check("spr_addr", 32'(spr_addr), in_str ? 32'(e_addr) : 32'h0);
            check("spr_data", spr_wdata, in_str ? e_wdata : 32'h0);
            check("m_ack", 32'(m_ack), 32'(exp_ack));
            check("m_err", 32'(m_err), 32'(exp_err));
            check("m_data", m_rdata, mdata);
            for (int i = 0; i < int'(NB); i++) begin
                if (m_ack[i] === 1'b1) begin
                    obs_q.push_back(i);
                    if (rst_cyc > 0 && cyc > rst_cyc && post_rst_idx < 0) post_rst_idx = i;
                end
            end

            if (rst) begin
                have_txn = 0; ptr = 0; mdata = '0; next_idle = cyc + 1;
            end else begin
                if (have_txn && cyc == t_grant + len) begin
                    if (txn_err) mdata = '0;
                    else if (!e_we) mdata = spr_rdata;
                end
                if (cyc >= next_idle) begin
                    gi = pick(m_stb, ptr);
                    if (gi >= 0) begin
                        have_txn = 1; g = gi; t_grant = cyc;
                        e_we = m_we[g]; e_addr = m_addr[g]; e_wdata = m_wdata[g];
                        if (lat_q.size() > 0) begin
                            lat = lat_q.pop_front();
                        end else begin
                            case ($urandom_range(0, 9))
                                0, 1:    lat = 0;
                                2:       lat = int'(TO);
                                default: lat = int'($urandom_range(1, TO));
                            endcase
                        end
                        txn_err   = (lat == 0);
                        len       = txn_err ? int'(TO) : lat;
                        ptr       = (g + 1) % NB;
                        next_idle = cyc + len + 2;
                    end else begin
                        next_idle = cyc + 1;
                    end
                end
            end
        end

        for (int i = 0; i < 4; i++)
            check($sformatf("contention_%0d", i), (i < obs_q.size()) ? 32'(obs_q[i]) : 32'hFFFF_FFFF,
                  32'(exp_order[i]));
        check("post_reset_winner", 32'(post_rst_idx), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
